key_debounce8: RTL and testbench
================================

KEY_DEBOUNCE8 -- requirements
Module: key_debounce8

Interface
REQ-001 The block SHALL have parameter N_LINES, default 8, meaning the number of independent key lines.
REQ-002 The block SHALL have parameter DB_CYCLES, default 1000, meaning the number of consecutive stable synchronized samples needed to accept a new level; legal range is 2..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops SHALL be rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port key_raw, input, N_LINES bits: asynchronous, bouncing, active-high key contacts.
REQ-006 The block SHALL have port D, output, N_LINES bits: debounced, stable key levels; this port directly feeds the 8-line priority encoder input.
REQ-007 The block SHALL have port press, output, N_LINES bits: a one-cycle pulse per line when D[i] goes 0->1.
REQ-008 The block SHALL have port release, output, N_LINES bits: a one-cycle pulse per line when D[i] goes 1->0.
REQ-009 The block SHALL have port chg, output, 1 bit: a one-cycle pulse, equal to the OR of all press and release bits in the same cycle.
REQ-010 The block SHALL have port any_down, output, 1 bit: the OR of all D bits, registered together with D.

Function
REQ-011 Each line SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-012 Each line SHALL have its own counter, ceil(log2(DB_CYCLES)) bits wide, that does not wrap.
REQ-013 Counter rule, per clock: if sync2[i] equals D[i], the counter SHALL be cleared to 0.
REQ-014 Counter rule, per clock: otherwise, if the counter equals DB_CYCLES-1, then D[i] SHALL take sync2[i], the counter SHALL be cleared, and the matching press or release bit SHALL pulse for exactly one cycle.
REQ-015 Counter rule, per clock: otherwise the counter SHALL increment by 1.
REQ-016 Each line SHALL behave as a two-state machine, IDLE (sync2==D) and COUNTING (sync2!=D); any bounce back to the D level SHALL return the line to IDLE with the count discarded.
REQ-017 Latency: a key_raw[i] level held constant SHALL appear on D[i] exactly DB_CYCLES+2 rising edges after the first edge that samples it.
REQ-018 press/release/chg SHALL be asserted in the same cycle that D changes.
REQ-019 Lines SHALL be fully independent; simultaneous transitions on several lines SHALL each produce their own pulse in the same cycle, and chg SHALL be a single one-cycle pulse.
REQ-020 A glitch shorter than DB_CYCLES synchronized cycles SHALL never change D or produce any pulse.
REQ-021 D SHALL never change by more than one level per line per DB_CYCLES cycles.
REQ-022 All outputs SHALL be registered; there SHALL be no combinational path from key_raw to any output.

Reset
REQ-023 While rst_n=0, sync1, sync2, D, all counters, press, release, chg and any_down SHALL all be 0, asynchronously.
REQ-024 Reset asserted mid-count SHALL discard all progress.
REQ-025 After reset release, a key already held SHALL be reported with a press pulse DB_CYCLES+2 edges later.
REQ-026 Reset deassertion SHALL be consumed as-is; upstream reset logic is responsible for synchronizing it.

Structure
REQ-027 The DB_CYCLES default and N_LINES default SHALL be defined in a shared package keypad_pkg, which the downstream encoder also uses.
REQ-028 Per-line logic (synchronizer, counter, state, edge pulses) SHALL be one sub-module, debounce_line, instantiated N_LINES times by a generate loop.
REQ-029 The top level SHALL only instantiate debounce_line and form chg and any_down.

Verification (DB_CYCLES=4 for all benches)
REQ-030 key_raw=8'h00->8'h04, held: D becomes 8'h04 and press=8'h04 for one cycle, 6 edges after the first sampling edge; chg=1 in that cycle only.
REQ-031 key_raw[2] toggles 1,0,1,0 at 2-cycle intervals, then settles at 1: no pulse during the toggling; D[2]=1 exactly 6 edges after it settles.
REQ-032 key_raw 8'h00->8'h81 in one cycle: press=8'h81 in a single cycle; chg pulses once; any_down=1 from the same cycle.
REQ-033 D=8'h10 stable, key_raw->8'h00: release=8'h10 for one cycle after 6 edges; D=8'h00; any_down=0.
REQ-034 Assert rst_n=0 on the 3rd counting cycle of key_raw=8'h02: all outputs 0 immediately; after release with raw still 8'h02, press[1] fires 6 edges later.
REQ-035 Random bounce (pulse widths 1-3 cycles) on all lines for 10k cycles against a reference model: no D change without a matching pulse, and D always equals the model.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: default line count and debounce depth used by the
// debouncer and the downstream priority encoder, plus the per-line state type.
package keypad_pkg;

    localparam int unsigned N_LINES_DEF   = 8;
    localparam int unsigned DB_CYCLES_DEF = 1000;

    // Legal debounce depth range.
    localparam int unsigned DB_CYCLES_MIN = 2;
    localparam int unsigned DB_CYCLES_MAX = 65535;

    // Per-line condition: sync2 agrees with D (IDLE) or disagrees (COUNTING).
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_COUNTING = 1'b1
    } line_state_e;

    // Counter width able to hold 0..cycles-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        if (cycles <= 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage : keypad_pkg

// File: rtl/debounce_line.sv
// Single key line debouncer: 2-flop synchronizer, non-wrapping stability
// counter and registered press/release edge pulses.
//   clk, rst_n      : rising-edge clock, async active-low reset
//   key_raw         : asynchronous bouncing contact
//   d               : debounced level
//   press, release_ : one-cycle pulses on d 0->1 / 1->0
//   *_nxt_c         : next-cycle values of d/press/release_, so the parent can
//                     register aggregate flags in step with them
module debounce_line
    import keypad_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic d,
    output logic press,
    output logic release_,
    output logic d_nxt_c,
    output logic press_nxt_c,
    output logic release_nxt_c
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    line_state_e   state_c;

    // State register: synchronizer, level, counter and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            d        <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
            release_ <= 1'b0;
        end else begin
            sync1    <= key_raw;
            sync2    <= sync1;
            d        <= d_nxt_c;
            cnt      <= cnt_nxt;
            press    <= press_nxt_c;
            release_ <= release_nxt_c;
        end
    end

    // Next-state logic. The state is the agreement between sync2 and d, so a
    // bounce back to the d level lands in IDLE and the count is dropped.
    always_comb begin
        state_c       = (sync2 == d) ? ST_IDLE : ST_COUNTING;
        d_nxt_c       = d;
        cnt_nxt       = '0;
        press_nxt_c   = 1'b0;
        release_nxt_c = 1'b0;
        case (state_c)
            ST_IDLE: begin
                cnt_nxt = '0;
            end
            ST_COUNTING: begin
                if (cnt == CNT_LAST) begin
                    // DB_CYCLES consecutive disagreeing samples: accept.
                    d_nxt_c       = sync2;
                    press_nxt_c   = sync2;
                    release_nxt_c = ~sync2;
                    cnt_nxt       = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

endmodule : debounce_line

// File: rtl/key_debounce8.sv
// Multi-line key debouncer feeding the keypad priority encoder.
//   clk, rst_n : rising-edge clock, async active-low reset (pre-synchronized)
//   key_raw    : N_LINES asynchronous bouncing key contacts, active high
//   D          : debounced key levels
//   press      : per-line one-cycle pulse on D 0->1
//   release_   : per-line one-cycle pulse on D 1->0
//   chg        : one-cycle pulse, OR of all press/release_ bits
//   any_down   : OR of D, registered alongside D
module key_debounce8
    import keypad_pkg::*;
#(
    parameter int unsigned N_LINES   = N_LINES_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] key_raw,
    output logic [N_LINES-1:0] D,
    output logic [N_LINES-1:0] press,
    output logic [N_LINES-1:0] release_,
    output logic               chg,
    output logic               any_down
);

    logic [N_LINES-1:0] d_nxt_c;
    logic [N_LINES-1:0] press_nxt_c;
    logic [N_LINES-1:0] release_nxt_c;

    // One independent debouncer per key line.
    for (genvar g = 0; g < N_LINES; g++) begin : g_line
        debounce_line #(
            .DB_CYCLES (DB_CYCLES)
        ) u_line (
            .clk           (clk),
            .rst_n         (rst_n),
            .key_raw       (key_raw[g]),
            .d             (D[g]),
            .press         (press[g]),
            .release_      (release_[g]),
            .d_nxt_c       (d_nxt_c[g]),
            .press_nxt_c   (press_nxt_c[g]),
            .release_nxt_c (release_nxt_c[g])
        );
    end

    // Aggregates are built from next-cycle line values so they register on
    // the same edge as D and the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg      <= 1'b0;
            any_down <= 1'b0;
        end else begin
            chg      <= |(press_nxt_c | release_nxt_c);
            any_down <= |d_nxt_c;
        end
    end

endmodule : key_debounce8

// File: tb/tb_key_debounce8.sv
// Randomized and directed bench for key_debounce8 with DB_CYCLES=4, checked
// against a sample-history reference model.
module tb_key_debounce8;

    localparam int unsigned NL = 8;
    localparam int unsigned DB = 4;

    logic          clk;
    logic          rst_n;
    logic [NL-1:0] raw;
    logic [NL-1:0] d;
    logic [NL-1:0] press;
    logic [NL-1:0] rel;
    logic          chg;
    logic          any_down;

    key_debounce8 #(
        .N_LINES   (NL),
        .DB_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_raw  (raw),
        .D        (d),
        .press    (press),
        .release_ (rel),
        .chg      (chg),
        .any_down (any_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: raw samples taken at each rising edge since reset; a
    // line accepts a new level once its two-edge-delayed sample has held a
    // value different from the accepted level for DB consecutive edges.
    logic [NL-1:0] hist[$];
    int            run_len[NL];
    logic [NL-1:0] last_e;
    logic [NL-1:0] m_d;
    logic [NL-1:0] m_press;
    logic [NL-1:0] m_rel;
    logic          m_chg;
    logic          m_any;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < NL; i++) run_len[i] = 0;
        last_e  = '0;
        m_d     = '0;
        m_press = '0;
        m_rel   = '0;
        m_chg   = 1'b0;
        m_any   = 1'b0;
    endtask

    task automatic model_step(input logic [NL-1:0] s, input logic rn);
        logic [NL-1:0] e;
        if (!rn) begin
            model_reset();
        end else begin
            hist.push_back(s);
            if (hist.size() > 3) void'(hist.pop_front());
            e = (hist.size() == 3) ? hist[0] : '0;
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < NL; i++) begin
                if (e[i] == last_e[i]) run_len[i] = run_len[i] + 1;
                else run_len[i] = 1;
                last_e[i] = e[i];
                if (e[i] != m_d[i] && run_len[i] >= DB) begin
                    m_d[i]     = e[i];
                    m_press[i] = e[i];
                    m_rel[i]   = ~e[i];
                end
            end
            m_chg = |(m_press | m_rel);
            m_any = |m_d;
        end
    endtask

    task automatic compare();
        chk("d",        32'(d),        32'(m_d));
        chk("press",    32'(press),    32'(m_press));
        chk("release",  32'(rel),      32'(m_rel));
        chk("chg",      32'(chg),      32'(m_chg));
        chk("any_down", 32'(any_down), 32'(m_any));
    endtask

    // One clock: model consumes the value the DUT samples, outputs checked at negedge.
    task automatic tick();
        logic [NL-1:0] s;
        logic          rn;
        s  = raw;
        rn = rst_n;
        @(posedge clk);
        model_step(s, rn);
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int            hold[NL];
    logic          pulse_seen;

    initial begin
        n_vec = 0;
        n_err = 0;
        raw   = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_d",   32'(d),        32'h0);
        chk("rst_chg", 32'(chg),      32'h0);
        chk("rst_any", 32'(any_down), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);

        // Single key press with exact latency.
        raw = 8'h04;
        ticks(5);
        chk("p1_d_early", 32'(d),     32'h00);
        chk("p1_press0",  32'(press), 32'h00);
        tick();
        chk("p1_d",       32'(d),     32'h04);
        chk("p1_press",   32'(press), 32'h04);
        chk("p1_chg",     32'(chg),   32'h1);
        tick();
        chk("p1_press_end", 32'(press), 32'h00);
        chk("p1_chg_end",   32'(chg),   32'h0);
        raw = 8'h00;
        ticks(8);
        chk("p1_released", 32'(d), 32'h00);

        // Bounce on line 2, then settle high.
        pulse_seen = 1'b0;
        for (int b = 0; b < 4; b++) begin
            raw = (b % 2 == 0) ? 8'h04 : 8'h00;
            for (int k = 0; k < 2; k++) begin
                tick();
                pulse_seen = pulse_seen | chg | (|press) | (|rel);
            end
        end
        chk("bounce_nopulse", 32'(pulse_seen), 32'h0);
        raw = 8'h04;
        ticks(5);
        chk("bounce_d_early", 32'(d), 32'h00);
        tick();
        chk("bounce_d", 32'(d),     32'h04);
        chk("bounce_p", 32'(press), 32'h04);
        raw = 8'h00;
        ticks(8);

        // Two lines pressed in the same cycle.
        raw = 8'h81;
        ticks(5);
        chk("dual_any_early", 32'(any_down), 32'h0);
        tick();
        chk("dual_press", 32'(press),    32'h81);
        chk("dual_chg",   32'(chg),      32'h1);
        chk("dual_any",   32'(any_down), 32'h1);
        tick();
        chk("dual_chg_end", 32'(chg), 32'h0);

        // Release from a single held key.
        raw = 8'h10;
        ticks(8);
        chk("rel_setup", 32'(d), 32'h10);
        raw = 8'h00;
        ticks(5);
        chk("rel_d_early", 32'(d), 32'h10);
        tick();
        chk("rel_pulse", 32'(rel),      32'h10);
        chk("rel_d",     32'(d),        32'h00);
        chk("rel_any",   32'(any_down), 32'h0);
        tick();
        chk("rel_pulse_end", 32'(rel), 32'h00);

        // Reset during counting; held key reported again after release.
        raw = 8'h02;
        ticks(4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_d",     32'(d),        32'h0);
        chk("mid_rst_press", 32'(press),    32'h0);
        chk("mid_rst_rel",   32'(rel),      32'h0);
        chk("mid_rst_chg",   32'(chg),      32'h0);
        chk("mid_rst_any",   32'(any_down), 32'h0);
        model_reset();
        ticks(2);
        rst_n = 1'b1;
        ticks(5);
        chk("post_rst_early", 32'(press), 32'h00);
        tick();
        chk("post_rst_press", 32'(press), 32'h02);
        chk("post_rst_d",     32'(d),     32'h02);
        raw = 8'h00;
        ticks(8);

        // Random bounce on all lines against the model.
        for (int i = 0; i < NL; i++) hold[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NL; i++) begin
                if (hold[i] == 0) begin
                    raw[i]  = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 12));
                end
                hold[i] = hold[i] - 1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_key_debounce8
